uart_rx_ctrl: RTL and testbench
===============================

Name: uart_rx_ctrl

Overview:
Receive-path controller for the UART. It sequences the 16x-oversampling receiver baud generator by driving `baud_gen_en` and consuming `rx_tick`. It detects and validates the start bit, majority-samples each data, parity and stop bit at mid-bit, and delivers the received byte with status flags. It sits between the asynchronous serial input pin and the receive FIFO/host logic.

Parameters:
DATA_BITS, 8, number of data bits per frame (5..9), sent LSB first
PARITY_EN, 0, 1 = a parity bit follows the data bits
PARITY_ODD, 0, 1 = odd parity, 0 = even parity (used only when PARITY_EN=1)

Ports:
rx_clk  input  1  receiver system clock; all logic is on its rising edge
rst  input  1  synchronous, active-high reset
rx_in  input  1  asynchronous serial line; idle level is 1
rx_tick  input  1  single-cycle 16x-oversample pulse from the receiver baud generator
baud_gen_en  output  1  enable to the receiver baud generator
rx_data  output  DATA_BITS  last received data word
rx_valid  output  1  one-cycle pulse: rx_data, frame_err and parity_err are updated
frame_err  output  1  stop bit sampled 0 for the frame just delivered
parity_err  output  1  parity mismatch for the frame just delivered (always 0 when PARITY_EN=0)
rx_busy  output  1  high whenever the state is not IDLE

Behaviour:
- Clock and reset: one clock, rx_clk. Reset is synchronous and active-high on rst.
- Reset values:
  - baud_gen_en=0, rx_data=0, rx_valid=0, frame_err=0, parity_err=0, rx_busy=0.
  - State=IDLE; synchronizer flops=1; tick_cnt=0; bit_cnt=0.
  - rst asserted mid-frame aborts the frame with no rx_valid.
- Synchronizer: rx_in passes through 2 flops to give rx_s, so 2 cycles of latency. All decisions use rx_s only.
- Counters:
  - tick_cnt is 4 bits and advances only on rx_tick, wrapping 15→0.
  - bit_cnt counts data bits.
- Sampling:
  - On rx_tick with tick_cnt = 6, 7 and 8, rx_s is captured into s0, s1, s2.
  - The vote is majority(s0, s1, s2) and is evaluated on the tick where tick_cnt=8.
- State machine:
  - IDLE:
    - baud_gen_en=0.
    - When rx_s==0: tick_cnt←0, go to START.
  - START:
    - At vote: if vote=1 (glitch), go to IDLE with no output.
    - At tick_cnt=15 tick: tick_cnt←0, bit_cnt←0, go to DATA.
  - DATA:
    - At vote: shift the vote in LSB first (the first received bit ends at rx_data[0]); bit_cnt++.
    - At tick_cnt=15 tick with bit_cnt==DATA_BITS: go to PARITY if PARITY_EN, else STOP.
  - PARITY:
    - At vote: store the received parity bit.
    - At tick_cnt=15 tick: go to STOP.
  - STOP (evaluated at vote, mid stop bit):
    - Always:
      - rx_data←shift register.
      - rx_valid=1 for exactly one cycle.
      - parity_err←(XOR of data ^ parity bit) != PARITY_ODD when PARITY_EN, else 0.
      - frame_err←~vote.
    - If vote=1: go to IDLE immediately, giving a half-bit early exit for resync.
    - If vote=0: go to BREAK.
  - BREAK: wait until rx_s==1, then go to IDLE. No start detection happens while in BREAK.
- Enable and busy outputs:
  - baud_gen_en = 1 in every state except IDLE; it is registered and reflects the next state.
  - rx_busy is decoded from the state.
- Tick alignment: the baud generator holds its count while disabled. Start-bit phase error is therefore up to one tick (1/16 bit), which is acceptable by design.
- Output holding: rx_data, frame_err and parity_err hold until the next rx_valid.
- rx_tick while IDLE is ignored.

Test Plan:
- 8N1 frame 0xA5 (line 0,1,0,1,0,0,1,0,1,1 at 16 rx_tick per bit):
  - baud_gen_en rises within 3 cycles of the start edge.
  - rx_valid pulses once; rx_data=0xA5, frame_err=0, parity_err=0.
  - rx_busy falls in the same cycle as IDLE is entered.
- Start glitch (rx_in low for 4 ticks, then high):
  - Returns to IDLE at tick_cnt=8 and baud_gen_en=0.
  - No rx_valid; rx_data keeps its previous value.
- Stop bit forced 0 for frame 0x3C:
  - rx_valid with rx_data=0x3C, frame_err=1.
  - FSM stays in BREAK (rx_busy=1) until rx_in returns high, then IDLE.
  - A following good frame 0x12 gives frame_err=0.
- PARITY_EN=1, PARITY_ODD=0, data 0x07 (odd count of ones):
  - Parity bit 1 → parity_err=0.
  - Parity bit 0 → parity_err=1.
  - Repeat with PARITY_ODD=1 and confirm the results invert.
- Noise rejection, frame 0xFF:
  - Force the line low on the tick_cnt=7 sample only in data bit 3.
  - rx_data=0xFF (majority vote wins); no error flags.
- Reset mid-frame (rst=1 for 1 cycle during data bit 4):
  - Next cycle: all outputs at reset values, baud_gen_en=0, no rx_valid.
  - A subsequent 0x5A frame is received correctly.

Source files
------------

// File: rtl/uart_rx_ctrl.sv
// Receive-path controller for a 16x-oversampled UART. It synchronises rx_in,
// votes on three mid-bit samples and returns each frame with its status flags.
module uart_rx_ctrl #(
  parameter int DATA_BITS  = 8,
  parameter bit PARITY_EN  = 1'b0,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic                 rx_clk,
  input  logic                 rst,
  input  logic                 rx_in,
  input  logic                 rx_tick,
  output logic                 baud_gen_en,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 rx_busy
);

  localparam int                 CNT_W     = $clog2(DATA_BITS + 1);
  localparam logic [CNT_W-1:0]   BITS_LAST = CNT_W'(DATA_BITS);

  typedef enum logic [2:0] {
    ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP, ST_BREAK
  } state_t;

  state_t               state, state_nxt;
  logic                 sync_q, rx_s;
  logic [3:0]           tick_cnt;
  logic [CNT_W-1:0]     bit_cnt;
  logic                 s0, s1;
  logic                 vote, vote_tick, end_tick;
  logic [DATA_BITS-1:0] shift_q;
  logic                 par_q;

  assign vote_tick = rx_tick && (tick_cnt == 4'd8);
  assign end_tick  = rx_tick && (tick_cnt == 4'd15);
  // The third sample is rx_s itself on the tick_cnt=8 tick, so the vote is ready that cycle.
  assign vote = (s0 & s1) | (s0 & rx_s) | (s1 & rx_s);

  // The synchroniser resets to the idle line level so reset never looks like a start bit.
  always_ff @(posedge rx_clk) begin
    if (rst) begin
      sync_q <= 1'b1;
      rx_s   <= 1'b1;
    end else begin
      sync_q <= rx_in;
      rx_s   <= sync_q;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge rx_clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      baud_gen_en <= 1'b0;
    end else begin
      state       <= state_nxt;
      baud_gen_en <= (state_nxt != ST_IDLE);
    end
  end

  // NOTE: default assignment first so no path through the case infers a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:   if (!rx_s) state_nxt = ST_START;
      ST_START: begin
        if (vote_tick && vote) state_nxt = ST_IDLE;
        else if (end_tick)     state_nxt = ST_DATA;
      end
      ST_DATA:   if (end_tick && (bit_cnt == BITS_LAST))
                   state_nxt = PARITY_EN ? ST_PARITY : ST_STOP;
      ST_PARITY: if (end_tick) state_nxt = ST_STOP;
      ST_STOP:   if (vote_tick) state_nxt = vote ? ST_IDLE : ST_BREAK;
      ST_BREAK:  if (rx_s) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    rx_busy = (state != ST_IDLE);
  end

  always_ff @(posedge rx_clk) begin
    if (rst) begin
      tick_cnt   <= 4'd0;
      bit_cnt    <= '0;
      s0         <= 1'b1;
      s1         <= 1'b1;
      shift_q    <= '0;
      par_q      <= 1'b0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      rx_valid <= 1'b0;

      // Ticks seen while idle are ignored; the start edge re-phases the count.
      if (state == ST_IDLE) begin
        if (!rx_s) tick_cnt <= 4'd0;
      end else if (rx_tick) begin
        tick_cnt <= tick_cnt + 4'd1;
      end

      if (rx_tick && (tick_cnt == 4'd6)) s0 <= rx_s;
      if (rx_tick && (tick_cnt == 4'd7)) s1 <= rx_s;

      if ((state == ST_START) && end_tick) bit_cnt <= '0;

      if ((state == ST_DATA) && vote_tick) begin
        shift_q <= {vote, shift_q[DATA_BITS-1:1]};
        bit_cnt <= bit_cnt + CNT_W'(1);
      end

      if ((state == ST_PARITY) && vote_tick) par_q <= vote;

      // Deliver at mid stop bit so the line can be re-watched half a bit early.
      if ((state == ST_STOP) && vote_tick) begin
        rx_data    <= shift_q;
        rx_valid   <= 1'b1;
        frame_err  <= ~vote;
        parity_err <= PARITY_EN ? ((^shift_q ^ par_q) != PARITY_ODD) : 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl: an 8N1 instance plus even- and odd-parity
// instances share clock, tick and reset; each has its own serial line.
`timescale 1ns/1ps
module tb_uart_rx_ctrl;

  logic       rx_clk  = 1'b0;
  logic       rst     = 1'b1;
  logic       rx_tick = 1'b0;
  logic [2:0] rx_line = 3'b111;
  logic [2:0] baud_gen_en, rx_valid, frame_err, parity_err, rx_busy;
  logic [7:0] rx_data [3];

  int   checks   = 0;
  int   failures = 0;
  int   valid_cnt [3];
  logic busy_at_valid [3];
  int   cyc = 0;
  int   mark_cyc = 0;
  int   start_cyc = 0;
  int   bg_rise_cyc = -100;
  logic bg_prev = 1'b0;

  always #5 rx_clk = ~rx_clk;
  always @(posedge rx_clk) cyc <= cyc + 1;

  // Record each rx_valid cycle and the busy level alongside it; record baud enable rise on line 0.
  always @(negedge rx_clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rx_valid[i] === 1'b1) begin
        valid_cnt[i]++;
        busy_at_valid[i] = rx_busy[i];
      end
    end
    if (baud_gen_en[0] === 1'b1 && bg_prev === 1'b0) bg_rise_cyc = cyc;
    bg_prev = baud_gen_en[0];
  end

  uart_rx_ctrl #(.DATA_BITS(8), .PARITY_EN(1'b0), .PARITY_ODD(1'b0)) u_8n1 (
    .rx_clk(rx_clk), .rst(rst), .rx_in(rx_line[0]), .rx_tick(rx_tick),
    .baud_gen_en(baud_gen_en[0]), .rx_data(rx_data[0]), .rx_valid(rx_valid[0]),
    .frame_err(frame_err[0]), .parity_err(parity_err[0]), .rx_busy(rx_busy[0]));

  uart_rx_ctrl #(.DATA_BITS(8), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) u_8e1 (
    .rx_clk(rx_clk), .rst(rst), .rx_in(rx_line[1]), .rx_tick(rx_tick),
    .baud_gen_en(baud_gen_en[1]), .rx_data(rx_data[1]), .rx_valid(rx_valid[1]),
    .frame_err(frame_err[1]), .parity_err(parity_err[1]), .rx_busy(rx_busy[1]));

  uart_rx_ctrl #(.DATA_BITS(8), .PARITY_EN(1'b1), .PARITY_ODD(1'b1)) u_8o1 (
    .rx_clk(rx_clk), .rst(rst), .rx_in(rx_line[2]), .rx_tick(rx_tick),
    .baud_gen_en(baud_gen_en[2]), .rx_data(rx_data[2]), .rx_valid(rx_valid[2]),
    .frame_err(frame_err[2]), .parity_err(parity_err[2]), .rx_busy(rx_busy[2]));

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One tick slot is four clocks with rx_tick high for the first.
  task automatic run_ticks(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge rx_clk); rx_tick = 1'b1;
      @(negedge rx_clk); rx_tick = 1'b0;
      @(negedge rx_clk);
      @(negedge rx_clk);
    end
  endtask

  // Sixteen tick slots; if glitch_k >= 0 the line is inverted only where tick glitch_k samples it.
  task automatic send_bit(input int sel, input logic val, input int glitch_k);
    for (int k = 0; k < 16; k++) begin
      @(negedge rx_clk);
      rx_tick = 1'b1;
      if (k == 0) begin
        rx_line[sel] = val;
        mark_cyc     = cyc;
      end
      @(negedge rx_clk); rx_tick = 1'b0;
      @(negedge rx_clk);
      if (k == glitch_k - 1)  rx_line[sel] = ~val;
      else if (k == glitch_k) rx_line[sel] = val;
      @(negedge rx_clk);
    end
  endtask

  // Frame bit index: 0 = start, 1..8 = data, then parity (optional), then stop.
  task automatic send_frame(input int sel, input logic [7:0] data, input bit par_en,
                            input logic par_bit, input logic stop_bit,
                            input int glitch_bit, input int abort_bit);
    logic [10:0] bits;
    int          n;
    bits    = '0;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[1+i] = data[i];
    n = 9;
    if (par_en) begin
      bits[n] = par_bit;
      n++;
    end
    bits[n] = stop_bit;
    n++;
    for (int b = 0; b < n; b++) begin
      if (b == abort_bit) begin
        rx_line[sel] = bits[b];
        run_ticks(4);
        @(negedge rx_clk); rst = 1'b1;
        @(negedge rx_clk); rst = 1'b0; rx_line[sel] = 1'b1;
        return;
      end
      send_bit(sel, bits[b], (b == glitch_bit) ? 8 : -1);
      if (b == 0) start_cyc = mark_cyc;
    end
  endtask

  initial begin
    int lat;

    // Reset state
    repeat (3) @(negedge rx_clk);
    check("rst_baud_gen_en", 16'(baud_gen_en[0]), 16'h0);
    check("rst_rx_data",     16'(rx_data[0]),     16'h00);
    check("rst_rx_valid",    16'(rx_valid[0]),    16'h0);
    check("rst_frame_err",   16'(frame_err[0]),   16'h0);
    check("rst_parity_err",  16'(parity_err[0]),  16'h0);
    check("rst_rx_busy",     16'(rx_busy),        16'h0);
    rst = 1'b0;
    run_ticks(4);

    // 8N1 frame 0xA5
    send_frame(0, 8'hA5, 1'b0, 1'b0, 1'b1, -1, -1);
    run_ticks(2);
    lat = bg_rise_cyc - start_cyc;
    check("a5_baud_en_latency_le3", 16'((lat >= 1) && (lat <= 3)), 16'h1);
    check("a5_valid_count",  16'(valid_cnt[0]), 16'd1);
    check("a5_rx_data",      16'(rx_data[0]),   16'hA5);
    check("a5_frame_err",    16'(frame_err[0]), 16'h0);
    check("a5_parity_err",   16'(parity_err[0]), 16'h0);
    check("a5_busy_at_valid", 16'(busy_at_valid[0]), 16'h0);
    check("a5_baud_en_idle", 16'(baud_gen_en[0]), 16'h0);

    // Start glitch: four low ticks, vote at tick_cnt=8 is high
    rx_line[0] = 1'b0;
    run_ticks(4);
    rx_line[0] = 1'b1;
    run_ticks(5);
    check("glitch_busy_before_vote", 16'(rx_busy[0]), 16'h1);
    run_ticks(1);
    check("glitch_busy_after_vote",  16'(rx_busy[0]), 16'h0);
    check("glitch_baud_en",          16'(baud_gen_en[0]), 16'h0);
    run_ticks(16);
    check("glitch_no_valid", 16'(valid_cnt[0]), 16'd1);
    check("glitch_data_held", 16'(rx_data[0]), 16'hA5);

    // Stop bit low on 0x3C, then break until the line returns high
    send_frame(0, 8'h3C, 1'b0, 1'b0, 1'b0, -1, -1);
    check("brk_valid_count",  16'(valid_cnt[0]), 16'd2);
    check("brk_rx_data",      16'(rx_data[0]),   16'h3C);
    check("brk_frame_err",    16'(frame_err[0]), 16'h1);
    check("brk_busy_at_valid", 16'(busy_at_valid[0]), 16'h1);
    run_ticks(8);
    check("brk_busy_held",    16'(rx_busy[0]), 16'h1);
    check("brk_baud_en_held", 16'(baud_gen_en[0]), 16'h1);
    rx_line[0] = 1'b1;
    repeat (4) @(negedge rx_clk);
    check("brk_exit_busy",    16'(rx_busy[0]), 16'h0);
    check("brk_exit_baud_en", 16'(baud_gen_en[0]), 16'h0);
    run_ticks(4);
    send_frame(0, 8'h12, 1'b0, 1'b0, 1'b1, -1, -1);
    check("post_brk_valid_count", 16'(valid_cnt[0]), 16'd3);
    check("post_brk_rx_data",     16'(rx_data[0]),   16'h12);
    check("post_brk_frame_err",   16'(frame_err[0]), 16'h0);

    // Parity on 0x07 (three ones): even then odd
    send_frame(1, 8'h07, 1'b1, 1'b1, 1'b1, -1, -1);
    check("even_p1_valid_count", 16'(valid_cnt[1]), 16'd1);
    check("even_p1_rx_data",     16'(rx_data[1]),   16'h07);
    check("even_p1_parity_err",  16'(parity_err[1]), 16'h0);
    check("even_p1_frame_err",   16'(frame_err[1]),  16'h0);
    run_ticks(2);
    send_frame(1, 8'h07, 1'b1, 1'b0, 1'b1, -1, -1);
    check("even_p0_valid_count", 16'(valid_cnt[1]), 16'd2);
    check("even_p0_parity_err",  16'(parity_err[1]), 16'h1);
    run_ticks(2);
    send_frame(2, 8'h07, 1'b1, 1'b1, 1'b1, -1, -1);
    check("odd_p1_valid_count", 16'(valid_cnt[2]), 16'd1);
    check("odd_p1_rx_data",     16'(rx_data[2]),   16'h07);
    check("odd_p1_parity_err",  16'(parity_err[2]), 16'h1);
    run_ticks(2);
    send_frame(2, 8'h07, 1'b1, 1'b0, 1'b1, -1, -1);
    check("odd_p0_valid_count", 16'(valid_cnt[2]), 16'd2);
    check("odd_p0_parity_err",  16'(parity_err[2]), 16'h0);
    run_ticks(2);

    // Noise on the tick_cnt=7 sample of data bit 3 of 0xFF
    send_frame(0, 8'hFF, 1'b0, 1'b0, 1'b1, 4, -1);
    check("noise_valid_count", 16'(valid_cnt[0]), 16'd4);
    check("noise_rx_data",     16'(rx_data[0]),   16'hFF);
    check("noise_frame_err",   16'(frame_err[0]), 16'h0);
    check("noise_parity_err",  16'(parity_err[0]), 16'h0);
    run_ticks(2);

    // Reset pulse during data bit 4 of 0xC3
    send_frame(0, 8'hC3, 1'b0, 1'b0, 1'b1, -1, 5);
    check("abort_baud_gen_en", 16'(baud_gen_en[0]), 16'h0);
    check("abort_rx_valid",    16'(rx_valid[0]),    16'h0);
    check("abort_rx_data",     16'(rx_data[0]),     16'h00);
    check("abort_frame_err",   16'(frame_err[0]),   16'h0);
    check("abort_parity_err",  16'(parity_err[0]),  16'h0);
    check("abort_rx_busy",     16'(rx_busy[0]),     16'h0);
    run_ticks(20);
    check("abort_no_valid",    16'(valid_cnt[0]),   16'd4);
    send_frame(0, 8'h5A, 1'b0, 1'b0, 1'b1, -1, -1);
    check("post_abort_valid_count", 16'(valid_cnt[0]), 16'd5);
    check("post_abort_rx_data",     16'(rx_data[0]),   16'h5A);
    check("post_abort_frame_err",   16'(frame_err[0]), 16'h0);
    run_ticks(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
